uart_tx_fifo: RTL

//   Parametrised serial transmitter. Successor to the fixed 8-bit, 16x-oversampled transmitter.
//   - Front: FIFO_DEPTH-entry character buffer.
//   - Framing: configurable data width, stop bits and oversample ratio; optional parity.
//   - Placement: sits between the parallel host interface and the serial line (data_out).
//   - Frames go out back-to-back while the buffer holds data and transmit_enable is high.

---
 rtl/uart_tx_fifo_if.sv | 27 ++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: enqueue strobe and character, frame
// start permission, serial line and buffer/transmitter status.
// The host side uses the master modport and the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
);
  logic [DATA_WIDTH-1:0]       data_in;
  logic                        load;
  logic                        transmit_enable;
  logic                        data_out;
  logic                        character_sent;
  logic                        busy;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] level;

  modport master (
    output data_in, load, transmit_enable,
    input  data_out, character_sent, busy, full, empty, level
  );

  modport slave (
    input  data_in, load, transmit_enable,
    output data_out, character_sent, busy, full, empty, level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered, parametrised serial transmitter.
// A FIFO_DEPTH-entry character buffer feeds a start/data/[parity]/stop framer.
// Characters are sent LSB first. Each bit is held for OVERSAMPLE clocks.
// Define PARITY_EN to insert a parity bit after the data bits.
// ODD_PARITY selects odd (1) or even (0) parity for that bit.
// Frames run back-to-back with no idle gap while data is buffered and
// transmit_enable is high when a frame would start.
module uart_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ODD_PARITY = 0
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [AW:0]   LVL_FULL  = (AW+1)'(FIFO_DEPTH);

  // Reject configurations the framer cannot represent
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("DATA_WIDTH must be 5..9");
  end
  if (OVERSAMPLE < 2) begin : g_bad_os
    $error("OVERSAMPLE must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end
  if (ODD_PARITY != 0 && ODD_PARITY != 1) begin : g_bad_parity
    $error("ODD_PARITY must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           level_q;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_WIDTH-1:0] shreg;
`ifdef PARITY_EN
  logic                  par_bit;
`endif
  logic                  full_i, empty_i;
  logic                  push, pop, bit_end, frame_end, line;

  assign full_i             = (level_q == LVL_FULL);
  assign empty_i            = (level_q == '0);
  assign bus.full           = full_i;
  assign bus.empty          = empty_i;
  assign bus.level          = level_q;
  assign bus.data_out       = line;
  assign bus.character_sent = frame_end;
  assign bus.busy           = (state != IDLE);

  // Next-state, line level, and buffer handshake decode.
  // A new frame may start from IDLE or on the final stop cycle.
  always_comb begin
    state_next = state;
    line       = 1'b1;
    bit_end    = (cnt == CNT_LAST);
    frame_end  = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
    push       = bus.load && !full_i;
    pop        = bus.transmit_enable && !empty_i && ((state == IDLE) || frame_end);
    case (state)
      IDLE: begin
        if (pop) state_next = START;
      end
      START: begin
        line = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        line = shreg[0];
        if (bit_end && bit_idx == BIT_LAST) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        line = par_bit;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        line = 1'b1;
        if (frame_end) state_next = pop ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Sample counter wraps every bit; bit and stop indices advance on bit ends
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else begin
      if (state == IDLE || bit_end) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
      if (state == DATA && bit_end)
        bit_idx <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BW'(1);
      if (state == STOP && bit_end)
        stop_idx <= frame_end ? 1'b0 : 1'b1;
    end
  end

  // Shift register loads the buffer head on pop and shifts right after each data bit
  always_ff @(posedge clk) begin
    if (pop)                           shreg <= mem[rd_ptr];
    else if (state == DATA && bit_end) shreg <= shreg >> 1;
  end

`ifdef PARITY_EN
  // Parity of the popped character, captured before shifting destroys it
  always_ff @(posedge clk) begin
    if (pop) par_bit <= (^mem[rd_ptr]) ^ (ODD_PARITY != 0);
  end
`endif

  // Buffer storage write; writes while full are dropped
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Buffer pointers and occupancy; a simultaneous push and pop leave level unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
